// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module      : vga_scanout
// Description : Framebuffer scan-out with integer pixel scaling and VGA timing.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scanout #(
    parameter int PX_WIDTH  = 160,
    parameter int PX_HEIGHT = 120,
    parameter int SCALE     = 4,
    parameter int CLK_DIV   = 4,
    parameter int MEM_LAT   = 1,
    parameter int H_VIS     = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VIS     = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] rmemaddr,
    input  logic [2:0]  memo,
    output logic [2:0]  vga_r,
    output logic [2:0]  vga_g,
    output logic [1:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        frame_start
);

    localparam logic [7:0]  c_div_last   = 8'(CLK_DIV - 1);
    localparam logic [15:0] c_h_vis      = 16'(H_VIS);
    localparam logic [15:0] c_hs_start   = 16'(H_VIS + H_FP);
    localparam logic [15:0] c_hs_end     = 16'(H_VIS + H_FP + H_SYNC);
    localparam logic [15:0] c_h_last     = 16'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] c_v_vis      = 16'(V_VIS);
    localparam logic [15:0] c_vs_start   = 16'(V_VIS + V_FP);
    localparam logic [15:0] c_vs_end     = 16'(V_VIS + V_FP + V_SYNC);
    localparam logic [15:0] c_v_last     = 16'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] c_scale_last = 16'(SCALE - 1);
    localparam logic [15:0] c_px_w       = 16'(PX_WIDTH);
    localparam logic [15:0] c_px_h       = 16'(PX_HEIGHT);

    // Memory data must settle before the following tick samples it.
    if (CLK_DIV <= MEM_LAT) begin : g_lat_violation
        $error("vga_scanout: CLK_DIV must exceed MEM_LAT");
    end

    logic [7:0]  r_div;
    logic [15:0] r_h_cnt, r_v_cnt;
    logic [15:0] r_fb_x, r_sub_x, r_fb_y, r_sub_y;
    logic        r_hs_d, r_vs_d, r_act_d, r_infb_d;

    logic        w_tick;
    logic [15:0] w_h_nxt, w_v_nxt;
    logic [15:0] w_fbx_nxt, w_subx_nxt, w_fby_nxt, w_suby_nxt;
    logic        w_raw_hs, w_raw_vs, w_raw_act, w_in_fb;
    logic [15:0] w_addr;

    assign w_tick = (r_div == c_div_last);

    // Position after the coming tick; address and raw flags are derived from it
    // so that they register in step with the counters.
    always_comb begin
        w_h_nxt    = r_h_cnt;
        w_v_nxt    = r_v_cnt;
        w_fbx_nxt  = r_fb_x;
        w_subx_nxt = r_sub_x;
        w_fby_nxt  = r_fb_y;
        w_suby_nxt = r_sub_y;
        if (r_h_cnt == c_h_last) begin
            w_h_nxt    = 16'd0;
            w_fbx_nxt  = 16'd0;
            w_subx_nxt = 16'd0;
            if (r_v_cnt == c_v_last) begin
                w_v_nxt    = 16'd0;
                w_fby_nxt  = 16'd0;
                w_suby_nxt = 16'd0;
            end else begin
                w_v_nxt = r_v_cnt + 16'd1;
                if (r_v_cnt < c_v_vis) begin
                    if (r_sub_y == c_scale_last) begin
                        w_suby_nxt = 16'd0;
                        w_fby_nxt  = r_fb_y + 16'd1;
                    end else begin
                        w_suby_nxt = r_sub_y + 16'd1;
                    end
                end
            end
        end else begin
            w_h_nxt = r_h_cnt + 16'd1;
            if (r_h_cnt < c_h_vis) begin
                if (r_sub_x == c_scale_last) begin
                    w_subx_nxt = 16'd0;
                    w_fbx_nxt  = r_fb_x + 16'd1;
                end else begin
                    w_subx_nxt = r_sub_x + 16'd1;
                end
            end
        end
    end

    assign w_raw_hs  = !((w_h_nxt >= c_hs_start) && (w_h_nxt < c_hs_end));
    assign w_raw_vs  = !((w_v_nxt >= c_vs_start) && (w_v_nxt < c_vs_end));
    assign w_raw_act = (w_h_nxt < c_h_vis) && (w_v_nxt < c_v_vis);
    assign w_in_fb   = w_raw_act && (w_fbx_nxt < c_px_w) && (w_fby_nxt < c_px_h);
    assign w_addr    = w_in_fb ? (w_fby_nxt * c_px_w) + w_fbx_nxt : 16'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div       <= 8'd0;
            r_h_cnt     <= 16'd0;
            r_v_cnt     <= 16'd0;
            r_fb_x      <= 16'd0;
            r_sub_x     <= 16'd0;
            r_fb_y      <= 16'd0;
            r_sub_y     <= 16'd0;
            rmemaddr    <= 16'd0;
            // Stage flags preloaded with the values for position (0,0),
            // which the counters hold when reset releases.
            r_hs_d      <= 1'b1;
            r_vs_d      <= 1'b1;
            r_act_d     <= 1'b1;
            r_infb_d    <= 1'b1;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            active      <= 1'b0;
            vga_r       <= 3'd0;
            vga_g       <= 3'd0;
            vga_b       <= 2'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            r_div       <= w_tick ? 8'd0 : r_div + 8'd1;
            if (w_tick) begin
                r_h_cnt  <= w_h_nxt;
                r_v_cnt  <= w_v_nxt;
                r_fb_x   <= w_fbx_nxt;
                r_sub_x  <= w_subx_nxt;
                r_fb_y   <= w_fby_nxt;
                r_sub_y  <= w_suby_nxt;
                rmemaddr <= w_addr;
                r_hs_d   <= w_raw_hs;
                r_vs_d   <= w_raw_vs;
                r_act_d  <= w_raw_act;
                r_infb_d <= w_in_fb;
                hsync    <= r_hs_d;
                vsync    <= r_vs_d;
                active   <= r_act_d;
                if (r_infb_d) begin
                    vga_r <= {3{memo[2]}};
                    vga_g <= {3{memo[1]}};
                    vga_b <= {2{memo[0]}};
                end else begin
                    vga_r <= 3'd0;
                    vga_g <= 3'd0;
                    vga_b <= 2'd0;
                end
                frame_start <= (w_h_nxt == 16'd0) && (w_v_nxt == c_v_vis);
            end
        end
    end

endmodule
`default_nettype wire
